// File: rtl/execute_stage.sv
// execute_stage: A/B/C register file, shift/xor/mod/jump execution and a
// 2-entry OUT FIFO that back-pressures decode through halt_id.
module execute_stage #(
    parameter int REG_W  = 64,
    parameter int PC_W   = 8,
    parameter int SQUASH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_load,
    input  logic [REG_W-1:0] init_a,
    input  logic [REG_W-1:0] init_b,
    input  logic [REG_W-1:0] init_c,
    input  logic             id_valid,
    input  logic [2:0]       operand,
    input  logic [1:0]       op1_sel,
    input  logic [1:0]       op2_sel,
    input  logic [1:0]       operation_sel,
    input  logic [4:0]       reg_wr_en,
    output logic             halt_id,
    output logic             jump_taken,
    output logic [PC_W-1:0]  jump_target,
    output logic             out_valid,
    output logic [2:0]       out_data,
    input  logic             out_ready,
    output logic [REG_W-1:0] reg_a,
    output logic [REG_W-1:0] reg_b,
    output logic [REG_W-1:0] reg_c,
    output logic             illegal_op
);
    localparam logic [1:0] OP_SHIFT = 2'd0, OP_XOR = 2'd1, OP_JUMP = 2'd3;
    localparam logic [1:0] SEL_B = 2'd0, SEL_C = 2'd1, SEL_LIT = 2'd2, SEL_COMBO = 2'd3;

    logic [REG_W-1:0] lit, combo, op1, op2, res;
    logic [1:0]       squash_cnt, fifo_cnt, wr_pos;
    logic [2:0]       fifo_e0, fifo_e1;
    logic             exec, squash, push, pop, fifo_full, combo_bad, unused_wr;

    assign unused_wr = reg_wr_en[4];
    assign lit       = REG_W'(operand);
    assign combo     = operand == 3'd4 ? reg_a :
                       operand == 3'd5 ? reg_b :
                       operand == 3'd6 ? reg_c :
                       operand == 3'd7 ? '0 : lit;
    assign op1       = op1_sel == SEL_B ? reg_b : op1_sel == SEL_C ? reg_c : op1_sel == SEL_LIT ? lit : combo;
    assign op2       = op2_sel == SEL_B ? reg_b : op2_sel == SEL_C ? reg_c : op2_sel == SEL_LIT ? lit : combo;
    assign res       = operation_sel == OP_SHIFT ? (combo >= REG_W ? '0 : reg_a >> combo) :
                       operation_sel == OP_XOR   ? op1 ^ op2 : op1 & REG_W'(7);
    // Only the operand slots an operation actually reads can trip illegal_op.
    assign combo_bad = operand == 3'd7 && (operation_sel == OP_SHIFT ||
                       (operation_sel != OP_JUMP && op1_sel == SEL_COMBO) ||
                       (operation_sel == OP_XOR && op2_sel == SEL_COMBO));

    assign out_valid = fifo_cnt != 2'd0;
    assign out_data  = fifo_e0;
    assign fifo_full = fifo_cnt == 2'd2;
    assign pop       = out_valid && out_ready;
    assign halt_id   = id_valid && reg_wr_en[3] && fifo_full && !pop && !init_load;
    assign exec      = id_valid && !halt_id && squash_cnt == 2'd0 && !init_load;
    assign squash    = id_valid && !halt_id && squash_cnt != 2'd0 && !init_load;
    assign push      = exec && operation_sel != OP_JUMP && reg_wr_en[3];
    assign wr_pos    = fifo_cnt - 2'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a       <= '0;
            reg_b       <= '0;
            reg_c       <= '0;
            fifo_cnt    <= '0;
            fifo_e0     <= '0;
            fifo_e1     <= '0;
            squash_cnt  <= '0;
            jump_taken  <= 1'b0;
            jump_target <= '0;
            illegal_op  <= 1'b0;
        end else if (init_load) begin
            reg_a       <= init_a;
            reg_b       <= init_b;
            reg_c       <= init_c;
            fifo_cnt    <= '0;
            squash_cnt  <= '0;
            jump_taken  <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            jump_taken <= exec && operation_sel == OP_JUMP && reg_a != '0;
            if (exec && operation_sel == OP_JUMP && reg_a != '0) begin
                jump_target <= PC_W'(operand);
                squash_cnt  <= 2'(SQUASH);
            end else if (squash)
                squash_cnt <= squash_cnt - 2'd1;
            if (exec && combo_bad)
                illegal_op <= 1'b1;
            if (exec && operation_sel != OP_JUMP) begin
                if (reg_wr_en[0]) reg_a <= res;
                if (reg_wr_en[1]) reg_b <= res;
                if (reg_wr_en[2]) reg_c <= res;
            end
            // A pop shifts the tail to the head; the push lands behind whatever remains.
            if (pop) fifo_e0 <= fifo_e1;
            if (push && wr_pos == 2'd0) fifo_e0 <= res[2:0];
            if (push && wr_pos == 2'd1) fifo_e1 <= res[2:0];
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end
endmodule
